// File: rtl/uart_angle_rx_if.sv
// Receiver output bundle: received byte, status pulses and the range-checked angle.
// The receiver drives it through the master modport; the servo driver reads it through the
// slave modport.
interface uart_angle_rx_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] angle;
    logic       angle_valid;

    modport master (
        output rx_data,
        output rx_done,
        output frame_err,
        output parity_err,
        output angle,
        output angle_valid
    );

    modport slave (
        input rx_data,
        input rx_done,
        input frame_err,
        input parity_err,
        input angle,
        input angle_valid
    );
endinterface

// File: rtl/uart_angle_rx.sv
// 8N1 serial receiver with mid-bit sampling and a range-checked angle register.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined; without it
// the frame is 10 bits and parity_err is tied to 0.
module uart_angle_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned ANGLE_MAX = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    uart_angle_rx_if.master  rx_if
);

    localparam int unsigned BitCntMax = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CntW      = $clog2(BitCntMax + 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(BitCntMax / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(BitCntMax - 1);
    localparam logic [7:0]      AngleMaxB = 8'(ANGLE_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      data_cnt_q, data_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      angle_q;
    logic            angle_valid_q;
    logic            sync1_q, sync2_q, hist_q;
    logic            line;
    logic            start_edge;
    logic            bit_end;

`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            parity_err_q, parity_err_d;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign line       = sync2_q;
    assign start_edge = hist_q & ~sync2_q;
    // After the mid-start clear, the last count of each period lands on the next bit's middle.
    assign bit_end    = (bit_cnt_q == LastCnt);

    // FSM, counters, shift register and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            data_cnt_q  <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_cnt_q  <= data_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: mid-bit sampling of start, data, optional parity and stop bits.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_end ? '0 : bit_cnt_q + 1'b1;
        data_cnt_d  = data_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (start_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_cnt_q == HalfCnt) begin
                    bit_cnt_d  = '0;
                    data_cnt_d = '0;
                    // A high line at mid-start means the edge was a glitch.
                    state_d    = line ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d    = {line, shift_q[7:1]};
                    data_cnt_d = data_cnt_q + 3'd1;
                    if (data_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    par_d   = line;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    // Back to idle at mid-stop so a start edge half a bit later is seen.
                    state_d = StIdle;
                    if (!line) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        rx_done_d = 1'b1;
                        rx_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Angle register: loads the byte reported by rx_done when it is within range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q       <= '0;
            angle_valid_q <= 1'b0;
        end else if (rx_done_q && (rx_data_q <= AngleMaxB)) begin
            angle_q       <= rx_data_q;
            angle_valid_q <= 1'b1;
        end
    end

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_done     = rx_done_q;
    assign rx_if.frame_err   = frame_err_q;
    assign rx_if.angle       = angle_q;
    assign rx_if.angle_valid = angle_valid_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err  = parity_err_q;
`else
    assign rx_if.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_angle_rx.sv
// Scoreboard bench for uart_angle_rx: each driven frame pushes its expected outcome,
// a monitor pops and compares whenever the receiver pulses.
module tb_uart_angle_rx;

    localparam int unsigned ClkFreq  = 1_600_000;
    localparam int unsigned BaudRate = 100_000;
    localparam int unsigned Bit      = ClkFreq / BaudRate;  // 16 clocks per bit
    localparam int unsigned AngleMax = 56;

    typedef struct {
        logic [2:0] kind;   // {rx_done, frame_err, parity_err}
        logic [7:0] data;   // rx_data expected while the pulse is high
        logic [7:0] angle;  // angle expected the cycle after rx_done
        logic       valid;
    } exp_t;

    logic clk;
    logic rst_n;
    logic data_in;

    uart_angle_rx_if rx_if ();

    uart_angle_rx #(
        .CLK_FREQ  (ClkFreq),
        .BAUD_RATE (BaudRate),
        .ANGLE_MAX (AngleMax)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .rx_if   (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         pulse_cnt = 0;
    logic [7:0] m_rx_data = '0;
    logic [7:0] m_angle   = '0;
    logic       m_valid   = 1'b0;
    bit         pend_angle = 0;
    exp_t       cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Model of one frame's outcome, pushed before the frame is driven.
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad);
        exp_t e;
        e.angle = m_angle;
        e.valid = m_valid;
        if (!stop_ok) begin
            e.kind = 3'b010;
            e.data = m_rx_data;
`ifdef UART_RX_PARITY_EN
        end else if (par_bad) begin
            e.kind = 3'b001;
            e.data = m_rx_data;
`endif
        end else begin
            m_rx_data = b;
            if (b <= 8'(AngleMax)) begin
                m_angle = b;
                m_valid = 1'b1;
            end
            e.kind  = 3'b100;
            e.data  = b;
            e.angle = m_angle;
            e.valid = m_valid;
        end
        if (par_bad && !stop_ok) e.kind = 3'b010;
        sb.push_back(e);
    endtask

    task automatic line_bit(input logic v);
        data_in = v;
        repeat (Bit) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_bad);
        expect_frame(b, stop_ok, par_bad);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        line_bit((^b) ^ par_bad);
`endif
        line_bit(stop_ok);
        data_in = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 4 * Bit) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check(tag, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_angle) begin
                check("angle", rx_if.angle, cur.angle);
                check("angle_valid", rx_if.angle_valid, cur.valid);
                pend_angle = 0;
            end
            if (rx_if.rx_done || rx_if.frame_err || rx_if.parity_err) begin
                pulse_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {rx_if.rx_done, rx_if.frame_err, rx_if.parity_err},
                          3'b000);
                end else begin
                    cur = sb.pop_front();
                    check("pulse_kind", {rx_if.rx_done, rx_if.frame_err, rx_if.parity_err},
                          cur.kind);
                    if (cur.kind != 3'b001) check("rx_data", rx_if.rx_data, cur.data);
                    if (rx_if.rx_done) pend_angle = 1;
                end
            end
        end
    end

    initial begin
        int p0;
        data_in = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_if.rx_data, 8'h00);
        check("rst_rx_done", rx_if.rx_done, 1'b0);
        check("rst_frame_err", rx_if.frame_err, 1'b0);
        check("rst_parity_err", rx_if.parity_err, 1'b0);
        check("rst_angle", rx_if.angle, 8'h00);
        check("rst_angle_valid", rx_if.angle_valid, 1'b0);
        rst_n = 1'b1;
        repeat (Bit) @(negedge clk);

        // Plain in-range byte.
        send_byte(8'h1C, 1'b1, 1'b0);
        wait_drain("drain_1c");

        // Short low glitch on the idle line.
        p0 = pulse_cnt;
        data_in = 1'b0;
        repeat (5) @(negedge clk);
        data_in = 1'b1;
        repeat (3 * Bit) @(negedge clk);
        check("glitch_quiet", pulse_cnt, p0);

        // Stop bit forced low.
        send_byte(8'h5A, 1'b0, 1'b0);
        wait_drain("drain_5a");
        check("hold_rx_data", rx_if.rx_data, 8'h1C);

        // Out-of-range byte: data updates, angle holds.
        send_byte(8'h64, 1'b1, 1'b0);
        wait_drain("drain_64");
        check("hold_angle", rx_if.angle, 8'd28);

        // Back-to-back frames, no idle gap.
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h38, 1'b1, 1'b0);
        wait_drain("drain_b2b");
        check("final_angle", rx_if.angle, 8'd56);

        // Break: line held low well past a frame -> exactly one frame_err.
        p0 = pulse_cnt;
        expect_frame(8'h00, 1'b0, 1'b0);
        data_in = 1'b0;
        repeat (20 * Bit) @(negedge clk);
        data_in = 1'b1;
        repeat (2 * Bit) @(negedge clk);
        wait_drain("drain_break");
        check("break_one_err", pulse_cnt - p0, 1);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch: parity_err instead of rx_done, angle held.
        send_byte(8'h03, 1'b1, 1'b1);
        wait_drain("drain_par");
        check("par_angle_held", rx_if.angle, 8'd56);
`endif

        // Reset in the middle of a frame.
        data_in = 1'b0;
        repeat (Bit) @(negedge clk);
        data_in = 1'b1;
        repeat (3 * Bit) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        pend_angle = 0;
        m_rx_data  = '0;
        m_angle    = '0;
        m_valid    = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_rx_data", rx_if.rx_data, 8'h00);
        check("midrst_angle_valid", rx_if.angle_valid, 1'b0);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (12 * Bit) @(negedge clk);
        check("midrst_quiet", pulse_cnt, p0);
        send_byte(8'h0A, 1'b1, 1'b0);
        wait_drain("drain_0a");
        check("post_rst_angle", rx_if.angle, 8'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
